// File: rtl/uart_bus_bridge_pkg.sv
// Shared definitions for the UART-to-bus debug bridge.
//   OP_WRITE / OP_READ : command opcodes ('W' / 'R')
//   RSP_ACK / RSP_ERR  : single-byte responses ('K' / '?')
//   state_e            : main frame/response state encoding
package uart_bus_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StAddr     = 3'd1,
        StData     = 3'd2,
        StBus      = 3'd3,
        StRespLoad = 3'd4,
        StRespWait = 3'd5
    } state_e;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Signal bundle between the bridge and its surroundings (UART receiver/sender and peripheral bus).
//   rx_data/rx_valid   : received byte and its one-cycle strobe
//   tx_data/tx_en      : byte to send and its one-cycle send strobe
//   tx_status          : sender idle flag (1 = idle)
//   rd/wr/addr/wdata   : single-cycle bus strobes, address and write data
//   rdata              : combinational bus read data
//   busy/frame_err     : bridge activity flag and error pulse
// master = bridge side, slave = environment side.
interface uart_bus_bridge_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_status;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        frame_err;

    modport master (
        input  rx_data, rx_valid, tx_status, rdata,
        output tx_data, tx_en, rd, wr, addr, wdata, busy, frame_err
    );

    modport slave (
        output rx_data, rx_valid, tx_status, rdata,
        input  tx_data, tx_en, rd, wr, addr, wdata, busy, frame_err
    );

endinterface

// File: rtl/uart_bus_bridge_txq.sv
// Response byte queue: holds up to four response bytes (MSB first) and runs the
// tx_en/tx_status handshake while the main FSM sits in RESP_LOAD / RESP_WAIT.
//   load/load_word/load_rem : capture a new response; load_rem = byte count - 1
//   in_load/in_wait         : main FSM is in RESP_LOAD / RESP_WAIT
//   tx_status               : sender idle flag
//   tx_data/tx_en           : registered byte and send strobe
//   fire                    : byte handed to the sender this cycle
//   wait_done               : sender finished the current byte
//   last                    : current byte is the final one of the response
module uart_bus_bridge_txq (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [1:0]  load_rem,
    input  logic        in_load,
    input  logic        in_wait,
    input  logic        tx_status,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        fire,
    output logic        wait_done,
    output logic        last
);

    logic [31:0] resp_q, resp_d;
    logic [1:0]  rem_q, rem_d;
    logic        first_q, first_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            resp_q    <= '0;
            rem_q     <= '0;
            first_q   <= 1'b0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            resp_q    <= resp_d;
            rem_q     <= rem_d;
            first_q   <= first_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
        end
    end

    assign fire      = in_load & tx_status;
    // The sender's idle flag only drops one cycle after tx_en, so the first
    // RESP_WAIT cycle still shows a stale "idle" and must be skipped.
    assign wait_done = in_wait & ~first_q & tx_status;
    assign last      = (rem_q == 2'd0);

    always_comb begin
        resp_d    = resp_q;
        rem_d     = rem_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        first_d   = 1'b0;
        if (load) begin
            resp_d = load_word;
            rem_d  = load_rem;
        end else if (fire) begin
            tx_data_d = resp_q[31:24];
            resp_d    = {resp_q[23:0], 8'h00};
            tx_en_d   = 1'b1;
            first_d   = 1'b1;
        end else if (wait_done && !last) begin
            rem_d = rem_q - 2'd1;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command-frame to peripheral-bus bridge (second bus master beside the CPU).
// Frames: 'W' A3..A0 D3..D0 -> one write cycle, reply 'K'.
//         'R' A3..A0        -> one read cycle, reply rdata MSB first.
//         any other opcode  -> reply '?', frame_err pulse.
// A stalled frame (TIMEOUT_CYCLES without a byte) is dropped with a frame_err pulse.
//   CLK, Reset : clock, asynchronous active-high reset
//   bus        : master modport of uart_bus_bridge_if (UART + bus signals)
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TIMEOUT_W      = 17
) (
    input  logic             CLK,
    input  logic             Reset,
    uart_bus_bridge_if.master bus
);

    localparam logic [TIMEOUT_W-1:0] TMO_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

    state_e               state_q, state_d;
    logic                 op_wr_q, op_wr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 frame_err_q, frame_err_d;

    logic        good_op, bad_op, timeout, in_frame;
    logic        load, fire, wait_done, last;
    logic [31:0] load_word;
    logic [1:0]  load_rem;

    assign good_op  = (bus.rx_data == OP_WRITE) || (bus.rx_data == OP_READ);
    assign bad_op   = (state_q == StIdle) && bus.rx_valid && !good_op;
    assign in_frame = (state_q == StAddr) || (state_q == StData);
    assign timeout  = in_frame && (tmo_q == TMO_MAX);

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.rx_valid) state_d = good_op ? StAddr : StRespLoad;
            StAddr: begin
                if (timeout) state_d = StIdle;
                else if (bus.rx_valid && cnt_q == 2'd3) state_d = op_wr_q ? StData : StBus;
            end
            StData: begin
                if (timeout) state_d = StIdle;
                else if (bus.rx_valid && cnt_q == 2'd3) state_d = StBus;
            end
            StBus:      state_d = StRespLoad;
            StRespLoad: if (fire) state_d = StRespWait;
            StRespWait: if (wait_done) state_d = last ? StIdle : StRespLoad;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs and response loading
    always_comb begin
        bus.rd      = (state_q == StBus) && !op_wr_q;
        bus.wr      = (state_q == StBus) && op_wr_q;
        bus.busy    = (state_q != StIdle);
        load        = (state_q == StBus) || bad_op;
        load_word   = {RSP_ERR, 24'h0};
        load_rem    = 2'd0;
        frame_err_d = bad_op || timeout;
        if (state_q == StBus) begin
            load_word = op_wr_q ? {RSP_ACK, 24'h0} : bus.rdata;
            load_rem  = op_wr_q ? 2'd0 : 2'd3;
        end
    end

    // Frame datapath
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            op_wr_q     <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            op_wr_q     <= op_wr_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        op_wr_d = op_wr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;
        if (!in_frame || bus.rx_valid) tmo_d = '0;
        else if (tmo_q != TMO_MAX)     tmo_d = tmo_q + TIMEOUT_W'(1);
        if (state_q == StIdle && bus.rx_valid && good_op) begin
            op_wr_d = (bus.rx_data == OP_WRITE);
            cnt_d   = 2'd0;
        end
        // cnt wraps 3->0 exactly when the state moves on, so it never overruns a field.
        if (bus.rx_valid && !timeout) begin
            if (state_q == StAddr) begin
                addr_d = {addr_q[23:0], bus.rx_data};
                cnt_d  = cnt_q + 2'd1;
            end else if (state_q == StData) begin
                wdata_d = {wdata_q[23:0], bus.rx_data};
                cnt_d   = cnt_q + 2'd1;
            end
        end
    end

    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.frame_err = frame_err_q;

    uart_bus_bridge_txq u_txq (
        .CLK       (CLK),
        .Reset     (Reset),
        .load      (load),
        .load_word (load_word),
        .load_rem  (load_rem),
        .in_load   (state_q == StRespLoad),
        .in_wait   (state_q == StRespWait),
        .tx_status (bus.tx_status),
        .tx_data   (bus.tx_data),
        .tx_en     (bus.tx_en),
        .fire      (fire),
        .wait_done (wait_done),
        .last      (last)
    );

endmodule
